// File: rtl/rvc_pkg.sv
// rvc_pkg: RV32 opcodes, RVC quadrants, C.NOP and packer state shared by the compressor and packer.
package rvc_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [1:0] Q0 = 2'b00;
    localparam logic [1:0] Q1 = 2'b01;
    localparam logic [1:0] Q2 = 2'b10;

    localparam logic [15:0] C_NOP = 16'h0001;

    typedef enum logic {EMPTY, HALF} pack_state_e;

    // x8..x15 are the only registers reachable by the 3-bit rd'/rs' fields
    function automatic logic is_creg(input logic [4:0] r);
        return r[4:3] == 2'b01;
    endfunction

    function automatic logic fits(input logic signed [31:0] v, input int lo, input int hi);
        return v >= lo && v <= hi;
    endfunction

endpackage

// File: rtl/rvc_compressor.sv
// rvc_compressor: combinational RV32I -> RVC mapping; first matching rule wins.
// Control-flow forms (C.J/C.JAL/C.JR/C.JALR/C.BEQZ/C.BNEZ) only when RVC_CF_EN is defined.
module rvc_compressor
    import rvc_pkg::*;
(
    input  logic [31:0] in_instr,
    output logic [15:0] c_instr,
    output logic        is_c
);

    logic [6:0] op;
    logic [6:0] f7;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [2:0] f3;
    logic signed [31:0] imm_i;
    logic signed [31:0] imm_s;
`ifdef RVC_CF_EN
    logic signed [31:0] imm_b;
    logic signed [31:0] imm_j;
`endif

    assign op    = in_instr[6:0];
    assign rd    = in_instr[11:7];
    assign f3    = in_instr[14:12];
    assign rs1   = in_instr[19:15];
    assign rs2   = in_instr[24:20];
    assign f7    = in_instr[31:25];
    assign imm_i = {{20{in_instr[31]}}, in_instr[31:20]};
    assign imm_s = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
`ifdef RVC_CF_EN
    assign imm_b = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
    assign imm_j = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
`endif

    // 16'h0000 is the architecturally illegal RVC word, so zero doubles as "no compressed form"
    assign is_c = |c_instr;

    always_comb begin
        c_instr = '0;
        if (in_instr[1:0] == 2'b11) begin
            case (op)
                OP_IMM: begin
                    if (f3 == 3'b000) begin
                        if (rd == 5'd0 && rs1 == 5'd0 && imm_i == 0)
                            c_instr = C_NOP;
                        else if (rs1 == 5'd0 && rd != 5'd0 && fits(imm_i, -32, 31))
                            c_instr = {3'b010, imm_i[5], rd, imm_i[4:0], Q1};
                        else if (rd == rs1 && rd != 5'd0 && imm_i != 0 && fits(imm_i, -32, 31))
                            c_instr = {3'b000, imm_i[5], rd, imm_i[4:0], Q1};
                        else if (rd == 5'd2 && rs1 == 5'd2 && imm_i[3:0] == 4'd0 && imm_i != 0 && fits(imm_i, -512, 496))
                            c_instr = {3'b011, imm_i[9], rd, imm_i[4], imm_i[6], imm_i[8:7], imm_i[5], Q1};
                        else if (rs1 == 5'd2 && is_creg(rd) && imm_i[1:0] == 2'b00 && fits(imm_i, 4, 1020))
                            c_instr = {3'b000, imm_i[5:4], imm_i[9:6], imm_i[2], imm_i[3], rd[2:0], Q0};
                        else if (rd != 5'd0 && rs1 != 5'd0 && imm_i == 0)
                            c_instr = {4'b1000, rd, rs1, Q2};
                    end else if (f3 == 3'b001) begin
                        if (f7 == 7'b0000000 && rd == rs1 && rd != 5'd0 && rs2 != 5'd0)
                            c_instr = {3'b000, 1'b0, rd, rs2, Q2};
                    end else if (f3 == 3'b101) begin
                        if ((f7 == 7'b0000000 || f7 == 7'b0100000) && rd == rs1 && is_creg(rd) && rs2 != 5'd0)
                            c_instr = {3'b100, 1'b0, 1'b0, f7[5], rd[2:0], rs2, Q1};
                    end else if (f3 == 3'b111) begin
                        if (rd == rs1 && is_creg(rd) && fits(imm_i, -32, 31))
                            c_instr = {3'b100, imm_i[5], 2'b10, rd[2:0], imm_i[4:0], Q1};
                    end
                end
                OP_LUI: begin
                    if (rd != 5'd0 && rd != 5'd2 && in_instr[31:17] == {15{in_instr[17]}} && in_instr[31:12] != 20'd0)
                        c_instr = {3'b011, in_instr[17], rd, in_instr[16:12], Q1};
                end
                OP_OP: begin
                    if (f7 == 7'b0000000 && f3 == 3'b000) begin
                        if (rd != 5'd0 && rs2 != 5'd0 && rs1 == 5'd0)
                            c_instr = {4'b1000, rd, rs2, Q2};
                        else if (rd != 5'd0 && rs2 != 5'd0 && rd == rs1)
                            c_instr = {4'b1001, rd, rs2, Q2};
                    end else if (rd == rs1 && is_creg(rd) && is_creg(rs2)) begin
                        if (f7 == 7'b0100000 && f3 == 3'b000)
                            c_instr = {6'b100011, rd[2:0], 2'b00, rs2[2:0], Q1};
                        else if (f7 == 7'b0000000 && f3 == 3'b100)
                            c_instr = {6'b100011, rd[2:0], 2'b01, rs2[2:0], Q1};
                        else if (f7 == 7'b0000000 && f3 == 3'b110)
                            c_instr = {6'b100011, rd[2:0], 2'b10, rs2[2:0], Q1};
                        else if (f7 == 7'b0000000 && f3 == 3'b111)
                            c_instr = {6'b100011, rd[2:0], 2'b11, rs2[2:0], Q1};
                    end
                end
                OP_LOAD: begin
                    if (f3 == 3'b010 && imm_i[1:0] == 2'b00) begin
                        if (is_creg(rd) && is_creg(rs1) && fits(imm_i, 0, 124))
                            c_instr = {3'b010, imm_i[5:3], rs1[2:0], imm_i[2], imm_i[6], rd[2:0], Q0};
                        else if (rd != 5'd0 && rs1 == 5'd2 && fits(imm_i, 0, 252))
                            c_instr = {3'b010, imm_i[5], rd, imm_i[4:2], imm_i[7:6], Q2};
                    end
                end
                OP_STORE: begin
                    if (f3 == 3'b010 && imm_s[1:0] == 2'b00) begin
                        if (is_creg(rs1) && is_creg(rs2) && fits(imm_s, 0, 124))
                            c_instr = {3'b110, imm_s[5:3], rs1[2:0], imm_s[2], imm_s[6], rs2[2:0], Q0};
                        else if (rs1 == 5'd2 && fits(imm_s, 0, 252))
                            c_instr = {3'b110, imm_s[5:2], imm_s[7:6], rs2, Q2};
                    end
                end
`ifdef RVC_CF_EN
                OP_JAL: begin
                    if (rd[4:1] == 4'd0 && fits(imm_j, -2048, 2046))
                        c_instr = {rd[0] ? 3'b001 : 3'b101, imm_j[11], imm_j[4], imm_j[9:8], imm_j[10],
                                   imm_j[6], imm_j[7], imm_j[3:1], imm_j[5], Q1};
                end
                OP_JALR: begin
                    if (f3 == 3'b000 && imm_i == 0 && rs1 != 5'd0 && rd[4:1] == 4'd0)
                        c_instr = {3'b100, rd[0], rs1, 5'd0, Q2};
                end
                OP_BRANCH: begin
                    if (f3[2:1] == 2'b00 && rs2 == 5'd0 && is_creg(rs1) && fits(imm_b, -256, 254))
                        c_instr = {2'b11, f3[0], imm_b[8], imm_b[4:3], rs1[2:0], imm_b[7:6], imm_b[2:1], imm_b[5], Q1};
                end
`endif
                default: c_instr = '0;
            endcase
        end
    end

endmodule

// File: rtl/rvc_compress_packer.sv
// rvc_compress_packer: compresses an RV32I stream and packs halfwords into little-endian words.
// Output is always registered (OUT_REG fixed at 1); define RVC_CF_EN to compress control flow.
module rvc_compress_packer
    import rvc_pkg::*;
#(
    parameter logic [15:0] PAD_HW = C_NOP
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic        flush_i,
    output logic        flush_ack,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_word,
    output logic        last_c
);

    logic [15:0] c_instr;
    logic        is_c;
    logic        accept;
    logic        do_flush;
    logic        emit;
    logic [15:0] pend_q;
    logic [15:0] pend_d;
    logic [31:0] word_d;
    pack_state_e state_q;
    pack_state_e state_d;

    rvc_compressor u_comp (
        .in_instr(in_instr),
        .c_instr (c_instr),
        .is_c    (is_c)
    );

    assign in_ready = ~out_valid | out_ready;
    assign accept   = in_valid & in_ready;
    assign do_flush = ~in_valid & in_ready & flush_i;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= EMPTY;
            pend_q    <= '0;
            out_valid <= 1'b0;
            out_word  <= '0;
            flush_ack <= 1'b0;
            last_c    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            out_valid <= emit | (out_valid & ~out_ready);
            out_word  <= word_d;
            flush_ack <= do_flush;
            if (accept)
                last_c <= is_c;
        end
    end

    // A 32-bit instruction landing on a pending halfword straddles two output words
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        word_d  = out_word;
        emit    = 1'b0;
        if (accept && state_q == EMPTY) begin
            state_d = is_c ? HALF : EMPTY;
            pend_d  = is_c ? c_instr : pend_q;
            word_d  = is_c ? out_word : in_instr;
            emit    = ~is_c;
        end else if (accept) begin
            state_d = is_c ? EMPTY : HALF;
            pend_d  = is_c ? pend_q : in_instr[31:16];
            word_d  = is_c ? {c_instr, pend_q} : {in_instr[15:0], pend_q};
            emit    = 1'b1;
        end else if (do_flush && state_q == HALF) begin
            state_d = EMPTY;
            word_d  = {PAD_HW, pend_q};
            emit    = 1'b1;
        end
    end

endmodule

// File: tb/tb_rvc_compress_packer.sv
// tb_rvc_compress_packer: vector table, directed corner sequences and a randomized halfword-queue model.
module tb_rvc_compress_packer;

`ifdef RVC_CF_EN
    localparam bit CF = 1'b1;
`else
    localparam bit CF = 1'b0;
`endif
    localparam int NV = 28;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_instr = '0;
    logic        flush_i = 1'b0;
    logic        out_ready = 1'b1;
    logic        in_ready;
    logic        flush_ack;
    logic        out_valid;
    logic [31:0] out_word;
    logic        last_c;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] instr;
        logic [15:0] c;
        bit          is_c;
        string       name;
    } vec_t;
    vec_t vecs[NV];

    logic [15:0] hq[$];
    logic [31:0] wq[$];
    bit          exp_last;

    rvc_compress_packer dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_instr (in_instr),
        .flush_i  (flush_i),
        .flush_ack(flush_ack),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_word (out_word),
        .last_c   (last_c)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] i);
        in_valid = 1'b1;
        in_instr = i;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic flush;
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
    endtask

    // Model: a stream of halfwords; every two form one output word, a flush pads an odd tail
    task automatic step(input bit v, input logic [31:0] i, input bit c, input logic [15:0] cw,
                        input bit fl, input bit ordy, output bit acc);
        bit fa;
        in_valid  = v;
        in_instr  = i;
        flush_i   = fl;
        out_ready = ordy;
        @(negedge clk);
        chk("rnd_in_ready", in_ready, !out_valid || ordy);
        acc = v && in_ready;
        fa  = !v && in_ready && fl;
        if (out_valid && ordy) begin
            if (wq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rnd_extra_word: got %h expected none", out_word);
            end else
                chk("rnd_word", out_word, wq.pop_front());
        end
        if (acc) begin
            if (c)
                hq.push_back(cw);
            else begin
                hq.push_back(i[15:0]);
                hq.push_back(i[31:16]);
            end
            exp_last = c;
        end
        if (fa && hq.size() == 1)
            hq.push_back(16'h0001);
        while (hq.size() >= 2) begin
            wq.push_back({hq[1], hq[0]});
            void'(hq.pop_front());
            void'(hq.pop_front());
        end
        @(posedge clk);
        #1;
        chk("rnd_flush_ack", flush_ack, fa);
        chk("rnd_last_c", last_c, exp_last);
        chk("rnd_out_valid", out_valid, wq.size() != 0);
    endtask

    initial begin
        bit acc, v, fl, hold;
        int idx;
        vecs[0]  = '{32'hFF010113, 16'h1141, 1'b1, "c.addi sp,-16"};
        vecs[1]  = '{32'h00000013, 16'h0001, 1'b1, "c.nop"};
        vecs[2]  = '{32'h00500513, 16'h4515, 1'b1, "c.li a0,5"};
        vecs[3]  = '{32'hFC010113, 16'h7139, 1'b1, "c.addi16sp -64"};
        vecs[4]  = '{32'h01010413, 16'h0800, 1'b1, "c.addi4spn s0,16"};
        vecs[5]  = '{32'h00058513, 16'h852E, 1'b1, "c.mv from addi"};
        vecs[6]  = '{32'h00001537, 16'h6505, 1'b1, "c.lui a0,1"};
        vecs[7]  = '{32'h12345537, 16'h0000, 1'b0, "lui wide"};
        vecs[8]  = '{32'h00351513, 16'h050E, 1'b1, "c.slli a0,3"};
        vecs[9]  = '{32'h40245413, 16'h8409, 1'b1, "c.srai s0,2"};
        vecs[10] = '{32'hFFF4F493, 16'h98FD, 1'b1, "c.andi s1,-1"};
        vecs[11] = '{32'h40940433, 16'h8C05, 1'b1, "c.sub"};
        vecs[12] = '{32'h00947433, 16'h8C65, 1'b1, "c.and"};
        vecs[13] = '{32'h00B50533, 16'h952E, 1'b1, "c.add"};
        vecs[14] = '{32'h00B00533, 16'h852E, 1'b1, "c.mv from add"};
        vecs[15] = '{32'h00442483, 16'h4044, 1'b1, "c.lw"};
        vecs[16] = '{32'h00C12083, 16'h40B2, 1'b1, "c.lwsp"};
        vecs[17] = '{32'h00942423, 16'hC404, 1'b1, "c.sw"};
        vecs[18] = '{32'h00112623, 16'hC606, 1'b1, "c.swsp"};
        vecs[19] = '{32'h10032283, 16'h0000, 1'b0, "lw off 256"};
        vecs[20] = '{32'h04028293, 16'h0000, 1'b0, "addi 64"};
        vecs[21] = '{32'h0012D293, 16'h0000, 1'b0, "srli non-prime"};
        vecs[22] = '{32'h00001141, 16'h0000, 1'b0, "not 32b encoding"};
        vecs[23] = '{32'h00946433, 16'h8C45, 1'b1, "c.or"};
        vecs[24] = '{32'h0000006F, CF ? 16'hA001 : 16'h0000, CF, "c.j 0"};
        vecs[25] = '{32'h00008067, CF ? 16'h8082 : 16'h0000, CF, "c.jr ra"};
        vecs[26] = '{32'h00040463, CF ? 16'hC401 : 16'h0000, CF, "c.beqz s0,8"};
        vecs[27] = '{32'h010000EF, CF ? 16'h2801 : 16'h0000, CF, "c.jal 16"};

        tick();
        tick();
        chk("rst out_valid", out_valid, 0);
        chk("rst out_word", out_word, 0);
        chk("rst flush_ack", flush_ack, 0);
        chk("rst last_c", last_c, 0);
        rst_n = 1'b1;
        chk("rst in_ready", in_ready, 1);

        send(32'hFF010113);
        chk("t1 first held", out_valid, 0);
        chk("t1 last_c", last_c, 1);
        send(32'hFF010113);
        chk("t1 valid", out_valid, 1);
        chk("t1 word", out_word, 32'h11411141);
        tick();
        flush();
        chk("t1 empty no output", out_valid, 0);
        chk("t1 empty flush_ack", flush_ack, 1);
        tick();
        chk("t1 ack one cycle", flush_ack, 0);

        send(32'h10032283);
        chk("t2 valid", out_valid, 1);
        chk("t2 word", out_word, 32'h10032283);
        chk("t2 last_c", last_c, 0);
        tick();

        send(32'hFF010113);
        send(32'h10032283);
        chk("t3 straddle word", out_word, 32'h22831141);
        flush();
        chk("t3 pad word", out_word, 32'h00011003);
        chk("t3 pad valid", out_valid, 1);
        chk("t3 flush_ack", flush_ack, 1);
        tick();
        flush();
        chk("t3 now empty", out_valid, 0);
        tick();

        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_instr  = 32'h10032283;
        tick();
        in_instr = 32'h04028293;
        for (int k = 0; k < 5; k++) begin
            chk("t4 in_ready low", in_ready, 0);
            chk("t4 word stable", out_word, 32'h10032283);
            chk("t4 valid held", out_valid, 1);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("t4 in_ready release", in_ready, 1);
        tick();
        in_valid = 1'b0;
        chk("t4 next word", out_word, 32'h04028293);
        chk("t4 next valid", out_valid, 1);
        tick();

        send(32'hFF010113);
        send(32'h0000006F);
        chk("t5 word", out_word, CF ? 32'hA0011141 : 32'h006F1141);
        flush();
        chk("t5 flush valid", out_valid, !CF);
        chk("t5 flush ack", flush_ack, 1);
        if (!CF)
            chk("t5 pad pend", out_word, 32'h00010000);
        tick();

        send(32'hFF010113);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        flush();
        chk("t6 no output", out_valid, 0);
        chk("t6 flush_ack", flush_ack, 1);
        out_ready = 1'b0;
        send(32'h10032283);
        chk("t6 pending", out_valid, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("t6 discarded valid", out_valid, 0);
        chk("t6 discarded word", out_word, 0);
        out_ready = 1'b1;
        tick();

        for (int k = 0; k < NV; k++) begin
            send(vecs[k].instr);
            chk({vecs[k].name, " last_c"}, last_c, vecs[k].is_c);
            if (vecs[k].is_c) begin
                chk({vecs[k].name, " held"}, out_valid, 0);
                flush();
                chk({vecs[k].name, " c_instr"}, out_word, {16'h0001, vecs[k].c});
            end else
                chk({vecs[k].name, " pass"}, out_word, vecs[k].instr);
            chk({vecs[k].name, " valid"}, out_valid, 1);
            tick();
        end

        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_last = 1'b0;
        hold = 1'b0;
        idx = 0;
        for (int n = 0; n < 3000; n++) begin
            if (!hold)
                idx = $urandom_range(0, NV - 1);
            v  = hold || ($urandom_range(0, 9) < 7);
            fl = !v && ($urandom_range(0, 3) == 0);
            step(v, vecs[idx].instr, vecs[idx].is_c, vecs[idx].c, fl, $urandom_range(0, 9) < 7, acc);
            hold = v && !acc;
        end
        step(1'b0, '0, 1'b0, '0, 1'b1, 1'b1, acc);
        for (int n = 0; n < 3; n++)
            step(1'b0, '0, 1'b0, '0, 1'b0, 1'b1, acc);
        chk("rnd drained words", wq.size(), 0);
        chk("rnd drained halves", hq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
